// File: rtl/pll_mdrp_pkg.sv
// rtl/pll_mdrp_pkg.sv - command, MD port opcode and FSM state encodings for the PLL MDRP controller
package pll_mdrp_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_APPLY = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        MDOPC_NOP   = 2'b00,
        MDOPC_WRITE = 2'b01,
        MDOPC_READ  = 2'b10,
        MDOPC_ADDR  = 2'b11
    } mdopc_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_OP_LO,
        ST_OP_HI,
        ST_RD_WAIT,
        ST_RSP,
        ST_RST_HOLD,
        ST_LOCK_WAIT
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with synchronous clear
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// rtl/pll_mdrp_ctrl.sv - command-driven sequencer for the PLL dynamic reconfiguration port
module pll_mdrp_ctrl
    import pll_mdrp_pkg::*;
#(
    parameter int RD_LAT       = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       pll_mdclk,
    output logic [1:0] pll_mdopc,
    output logic       pll_mdainc,
    output logic [7:0] pll_mdwdi,
    input  logic [7:0] pll_mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock
);

    localparam int RD_W   = $clog2(RD_LAT) + 1;
    localparam int RST_W  = $clog2(RST_CYCLES) + 1;
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_LAT - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

    state_e            state, state_d;
    cmd_op_e           op_q;
    logic [7:0]        addr_q, wdata_q;
    logic              err_q, err_d;
    logic              accept;
    logic              rd_hi;
    logic [RD_W-1:0]   rd_cnt;
    logic [RST_W-1:0]  rst_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_s;
    logic [1:0]        opc_d;
    logic [7:0]        wdi_d;

    assign accept     = cmd_valid && cmd_ready;
    assign pll_mdainc = 1'b0;

    // Held clear while the PLL is in reset so a stale lock cannot qualify after release.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pll_reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        err_d   = err_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    case (cmd_op_e'(cmd_op))
                        OP_READ, OP_WRITE: state_d = ST_ADDR_LO;
                        OP_APPLY:          state_d = ST_RST_HOLD;
                        default: begin
                            state_d = ST_RSP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_ADDR_LO: state_d = ST_ADDR_HI;
            ST_ADDR_HI: state_d = ST_OP_LO;
            ST_OP_LO:   state_d = ST_OP_HI;
            ST_OP_HI:   state_d = (op_q == OP_READ) ? ST_RD_WAIT : ST_RSP;
            ST_RD_WAIT: if (rd_hi && rd_cnt == RD_LAST) state_d = ST_RSP;
            ST_RSP:     state_d = ST_IDLE;
            ST_RST_HOLD: if (rst_cnt == RST_LAST) state_d = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                if (lock_s) begin
                    state_d = ST_RSP;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_d = ST_RSP;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_READ;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op_e'(cmd_op);
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            err_q <= err_d;
        end
    end

    // Each counter is cleared whenever its state is not active, and saturates at its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_hi    <= 1'b0;
            rd_cnt   <= '0;
            rst_cnt  <= '0;
            lock_cnt <= '0;
        end else begin
            if (state != ST_RD_WAIT) begin
                rd_hi  <= 1'b0;
                rd_cnt <= '0;
            end else begin
                rd_hi <= !rd_hi;
                if (rd_hi && rd_cnt != RD_LAST) rd_cnt <= rd_cnt + 1'b1;
            end
            if (state != ST_RST_HOLD)    rst_cnt <= '0;
            else if (rst_cnt != RST_LAST) rst_cnt <= rst_cnt + 1'b1;
            if (state != ST_LOCK_WAIT)      lock_cnt <= '0;
            else if (lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 1'b1;
        end
    end

    always_comb begin
        opc_d = MDOPC_NOP;
        wdi_d = 8'h00;
        case (state)
            ST_ADDR_LO, ST_ADDR_HI: begin
                opc_d = MDOPC_ADDR;
                wdi_d = addr_q;
            end
            ST_OP_LO, ST_OP_HI: begin
                if (op_q == OP_WRITE) begin
                    opc_d = MDOPC_WRITE;
                    wdi_d = wdata_q;
                end else begin
                    opc_d = MDOPC_READ;
                end
            end
            default: ;
        endcase
    end

    // Handshake flags follow the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
            pll_reset <= 1'b0;
            pll_mdclk <= 1'b0;
            pll_mdopc <= MDOPC_NOP;
            pll_mdwdi <= 8'h00;
        end else begin
            cmd_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            rsp_valid <= (state == ST_RSP);
            rsp_err   <= (state == ST_RSP) && err_q;
            if (state == ST_RSP) rsp_rdata <= (op_q == OP_READ) ? pll_mdrdo : 8'h00;
            pll_reset <= (state == ST_RST_HOLD);
            pll_mdclk <= (state == ST_ADDR_HI) || (state == ST_OP_HI) ||
                         ((state == ST_RD_WAIT) && rd_hi);
            pll_mdopc <= opc_d;
            pll_mdwdi <= wdi_d;
        end
    end

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// tb/tb_pll_mdrp_ctrl.sv - directed self-checking bench for pll_mdrp_ctrl
module tb_pll_mdrp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       pll_mdclk;
    logic [1:0] pll_mdopc;
    logic       pll_mdainc;
    logic [7:0] pll_mdwdi;
    logic [7:0] pll_mdrdo;
    logic       pll_reset;
    logic       pll_lock = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;
    int n_acc  = 0;
    logic [1:0] p_opc[$];
    logic [7:0] p_wdi[$];
    logic [7:0] md_addr = 8'h00;

    always #5 clk = ~clk;

    pll_mdrp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .pll_mdclk  (pll_mdclk),
        .pll_mdopc  (pll_mdopc),
        .pll_mdainc (pll_mdainc),
        .pll_mdwdi  (pll_mdwdi),
        .pll_mdrdo  (pll_mdrdo),
        .pll_reset  (pll_reset),
        .pll_lock   (pll_lock)
    );

    // PLL register model: address latched by an ADDR op, fixed contents per address.
    assign pll_mdrdo = (md_addr == 8'h08) ? 8'h3C : 8'h5A;

    always @(negedge clk) begin
        if (pll_mdclk) begin
            p_opc.push_back(pll_mdopc);
            p_wdi.push_back(pll_mdwdi);
            if (pll_mdopc == 2'b11) md_addr = pll_mdwdi;
        end
        if (cmd_valid && cmd_ready) n_acc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pulse_at(input int i);
        if (i < p_opc.size()) return {p_opc[i], p_wdi[i]};
        return 10'h3FF;
    endfunction

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("send_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("acc_busy", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_rsp(output int cyc, input int limit);
        cyc = 0;
        while (!rsp_valid && cyc < limit) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic run_apply(input int lock_at, output int hi, output int rel, output logic err);
        int t = 0;
        hi = 0; rel = -1;
        send(2'b10, 8'h00, 8'h00);
        while (!rsp_valid && t < 6000) begin
            @(posedge clk); #1; t++;
            if (pll_reset) hi++;
            else if (hi > 0) rel++;
            if (rel == lock_at) pll_lock = 1'b1;
        end
        err = rsp_err;
        pll_lock = 1'b0;
    endtask

    initial begin
        int c, base, hi, rel, t, seen;
        logic err;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hs", {cmd_ready, rsp_valid, rsp_err, busy}, 4'h0);
        check("rst_md", {pll_mdclk, pll_mdopc, pll_mdainc, pll_mdwdi, pll_reset}, 13'h0);
        check("rst_rdata", rsp_rdata, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", {cmd_ready, busy}, 2'b10);

        // WRITE 0x12 <- 0xA5
        base = p_opc.size();
        send(2'b01, 8'h12, 8'hA5);
        wait_rsp(c, 50);
        check("wr_lat", c, 5);
        check("wr_err", rsp_err, 1'b0);
        check("wr_npulse", p_opc.size() - base, 2);
        check("wr_p0", pulse_at(base), {2'b11, 8'h12});
        check("wr_p1", pulse_at(base + 1), {2'b01, 8'hA5});
        @(posedge clk); #1;
        check("wr_onepulse", rsp_valid, 1'b0);

        // READ 0x08 -> 0x3C
        base = p_opc.size();
        send(2'b00, 8'h08, 8'hFF);
        wait_rsp(c, 50);
        check("rd_lat", c, 9);
        check("rd_data", rsp_rdata, 8'h3C);
        check("rd_err", rsp_err, 1'b0);
        check("rd_npulse", p_opc.size() - base, 4);
        check("rd_p0", pulse_at(base), {2'b11, 8'h08});
        check("rd_p1", pulse_at(base + 1), {2'b10, 8'h00});
        check("rd_p2", pulse_at(base + 2), {2'b00, 8'h00});
        check("rd_p3", pulse_at(base + 3), {2'b00, 8'h00});
        repeat (3) @(posedge clk);
        #1;
        check("rd_hold", rsp_rdata, 8'h3C);

        // READ 0x40 -> 0x5A, then WRITE clears rdata
        send(2'b00, 8'h40, 8'h00);
        wait_rsp(c, 50);
        check("rd2_lat", c, 9);
        check("rd2_data", rsp_rdata, 8'h5A);
        send(2'b01, 8'h40, 8'h11);
        wait_rsp(c, 50);
        check("wr2_rdata", rsp_rdata, 8'h00);

        // Reserved op
        base = p_opc.size();
        send(2'b11, 8'h33, 8'h44);
        wait_rsp(c, 20);
        check("rsv_lat", c, 1);
        check("rsv_err", rsp_err, 1'b1);
        check("rsv_rdata", rsp_rdata, 8'h00);
        check("rsv_npulse", p_opc.size() - base, 0);

        // cmd_valid held high across three WRITEs: 6 cycles per command
        @(posedge clk); #1;
        base = n_acc; seen = 0; t = 0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h20; cmd_wdata = 8'h01;
        while (seen < 3 && t < 100) begin
            @(posedge clk); #1; t++;
            if (rsp_valid) seen++;
        end
        cmd_valid = 1'b0;
        check("b2b_cycles", t, 18);
        check("b2b_acc", n_acc - base, 3);
        send(2'b11, 8'h00, 8'h00);
        @(posedge clk); #1;
        check("b2b_rsv", {rsp_valid, rsp_err}, 2'b11);

        // Reset during OP_HI of a WRITE
        send(2'b01, 8'h55, 8'h66);
        repeat (3) @(posedge clk);
        #1;
        check("mid_oplo", {pll_mdclk, pll_mdopc}, 3'b001);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_md", {pll_mdclk, pll_mdopc, pll_mdwdi}, 11'h0);
        check("mid_hs", {rsp_valid, busy, cmd_ready}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_ready", cmd_ready, 1'b1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("mid_norsp", seen, 0);

        // APPLY, lock high at the 100th edge after release
        run_apply(99, hi, rel, err);
        check("ap_hold", hi, 16);
        check("ap_within", rel <= 103 && rel >= 0, 1'b1);
        check("ap_err", err, 1'b0);

        // APPLY, lock already high: must wait for the synchroniser to refill
        pll_lock = 1'b1;
        run_apply(-5, hi, rel, err);
        check("pre_rel", rel, 4);
        check("pre_err", err, 1'b0);

        // APPLY, lock never rises
        run_apply(-5, hi, rel, err);
        check("to_hold", hi, 16);
        check("to_rel", rel, 4095);
        check("to_err", err, 1'b1);
        @(posedge clk); #1;
        check("to_idle", {busy, cmd_ready, pll_reset}, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pll_mdrp_ctrl.md
PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 Parameter RD_LAT, default 2: number of MDCLK periods from the READ-op rising edge until pll_mdrdo is sampled.
REQ-002 Parameter RST_CYCLES, default 16: clk cycles pll_reset is held high during APPLY.
REQ-003 Parameter LOCK_TIMEOUT, default 4095: clk cycles allowed for synchronised lock to rise after pll_reset release.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  controller accepts the command this cycle.
REQ-008 cmd_op  in  2  command: 00 READ, 01 WRITE, 10 APPLY, 11 reserved.
REQ-009 cmd_addr  in  8  PLL register address.
REQ-010 cmd_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  8  read data; 0 for WRITE and APPLY.
REQ-013 rsp_err  out  1  qualifies rsp_valid: lock timeout or reserved op.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 pll_mdclk, pll_mdopc[1:0], pll_mdainc, pll_mdwdi[7:0]  out  PLL dynamic-reconfiguration port drive.
REQ-016 pll_mdrdo  in  8  PLL read data.
REQ-017 pll_reset  out  1  PLL reset.
REQ-018 pll_lock  in  1  PLL lock, asynchronous to clk.

Function
REQ-019 MDOPC encoding: 00 NOP, 01 WRITE, 10 READ, 11 ADDR (address taken from MDWDI); pll_mdainc is held at 0.
REQ-020 Each MD op is 2 clk cycles: LO phase drives opc/wdi with mdclk=0, HI phase keeps them stable with mdclk=1; mdclk idles at 0 and opc idles at NOP.
REQ-021 Every output is registered.
REQ-022 cmd_ready = 1 only in IDLE; a command is accepted when cmd_valid & cmd_ready, and op/addr/wdata are captured on acceptance.
REQ-023 States: IDLE, ADDR_LO, ADDR_HI, OP_LO, OP_HI, RD_WAIT, RSP, RST_HOLD, LOCK_WAIT.
REQ-024 READ/WRITE path: IDLE -> ADDR_LO/HI (opc=11, wdi=addr) -> OP_LO/HI (opc=01 with wdi=wdata, or opc=10) -> WRITE goes to RSP; READ goes to RD_WAIT.
REQ-025 RD_WAIT emits RD_LAT further mdclk pulses with opc=NOP, then captures pll_mdrdo into rsp_rdata and goes to RSP.
REQ-026 WRITE latency, acceptance to rsp_valid: 5 cycles.
REQ-027 READ latency, acceptance to rsp_valid: 5+2*RD_LAT cycles.
REQ-028 RSP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata holds its value until the next RSP.
REQ-029 APPLY: RST_HOLD drives pll_reset=1 for RST_CYCLES cycles, then LOCK_WAIT with pll_reset=0.
REQ-030 LOCK_WAIT: synchronised lock=1 -> RSP with rsp_err=0; counter reaching LOCK_TIMEOUT -> RSP with rsp_err=1.
REQ-031 Lock already high entering LOCK_WAIT: it is qualified only after the 2-flop synchroniser has been refilled post-release, i.e. at least 2 cycles in LOCK_WAIT.
REQ-032 Reserved op 11: no MD activity; RSP with rsp_err=1 on the cycle after acceptance.
REQ-033 Counters are sized by $clog2 of their parameter plus 1 and never wrap; each is cleared on state entry.
REQ-034 cmd_valid while busy is ignored (no queuing).

Reset
REQ-035 rst_n=0 at a clk edge: state IDLE, all outputs 0 (opc NOP, mdclk 0, pll_reset 0), counters and synchroniser cleared.
REQ-036 Reset mid-operation aborts without a response; the MD port returns to idle on the following cycle.

Structure
REQ-037 Package pll_mdrp_pkg holds the cmd_op and MDOPC encodings and the state enum.
REQ-038 Sub-module sync_2ff synchronises pll_lock.

Verification
REQ-039 WRITE addr 0x12 data 0xA5 -> opc sequence 11(0x12), 01(0xA5); exactly 2 mdclk pulses; rsp_valid 5 cycles after acceptance; rsp_err=0.
REQ-040 READ addr 0x08 with RD_LAT=2, model returns 0x3C -> 4 mdclk pulses; rsp_rdata=0x3C 9 cycles after acceptance.
REQ-041 APPLY, model raises lock 100 cycles after reset release -> pll_reset high 16 cycles; rsp_valid with rsp_err=0 within 103 cycles of release.
REQ-042 APPLY with lock held low -> rsp_err=1 after 4095 cycles in LOCK_WAIT.
REQ-043 rst_n low during OP_HI of a WRITE -> next cycle opc=NOP, mdclk=0, no rsp_valid, cmd_ready=1 once rst_n is released.
REQ-044 cmd_valid held high with back-to-back commands plus op 11 -> one acceptance per IDLE visit; op 11 gives an error response on the cycle after acceptance.
